// File: rtl/reduction_sched_if.sv
// Requester/consumer bus of the shared GF(2^m) reduction scheduler.
// The master side holds the requesters and the result consumer; the slave side is the scheduler.
interface reduction_sched_if #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4
);
  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                     req_valid;
  logic [NUM_REQ-1:0]                     req_ready;
  logic [NUM_REQ-1:0][GW-1:0]             req_grade;
  logic [NUM_REQ-1:0][DATA_WIDTH:0]       req_poly;
  logic [NUM_REQ-1:0][2*DATA_WIDTH-1:0]   req_data;
  logic                                   rsp_valid;
  logic                                   rsp_ready;
  logic [IW-1:0]                          rsp_id;
  logic [DATA_WIDTH-1:0]                  rsp_data;
  logic                                   rsp_err;

  modport master (
    output req_valid, req_grade, req_poly, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_grade, req_poly, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/reduction_sched.sv
// Round-robin scheduler sharing one combinational GF(2^m) reducer between NUM_REQ requesters.
// One job in flight: IDLE (grant+capture) -> CALC (reduce+register) -> RESP (hold until accepted).

module reduction_sched_reducer #(
  parameter int DW = 4,
  parameter int GW = 3
) (
  input  logic [GW-1:0]     grade,
  input  logic [DW:0]       poly,
  input  logic [2*DW-1:0]   data,
  output logic [DW-1:0]     res,
  output logic              err
);
  logic [2*DW-1:0] pm;
  logic [2*DW-1:0] r;
  int              gi;

  always_comb begin
    gi  = int'(grade);
    err = (gi < 2) || (gi > DW);
    pm  = '0;
    // Coefficients above the grade are ignored so the leading term lands exactly on bit k.
    for (int k = 0; k <= DW; k++) pm[k] = poly[k] && (k <= gi);
    r = data;
    if (!err) begin
      for (int k = 2*DW-1; k >= 0; k--) begin
        if (k >= gi && r[k]) r = r ^ (pm << (k - gi));
      end
    end
    res = '0;
    for (int k = 0; k < DW; k++) res[k] = r[k] && (k < gi) && !err;
  end
endmodule

module reduction_sched #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  reduction_sched_if.slave   bus,
  output logic               busy
);
  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t                    state, state_n;
  logic [IW-1:0]             rr_ptr;
  logic [GW-1:0]             cap_grade;
  logic [DATA_WIDTH:0]       cap_poly;
  logic [2*DATA_WIDTH-1:0]   cap_data;
  logic [IW-1:0]             cap_id;
  logic [DATA_WIDTH-1:0]     rsp_data_q;
  logic                      rsp_err_q;
  logic [DATA_WIDTH-1:0]     red_res;
  logic                      red_err;

  logic [NUM_REQ-1:0]        gnt;
  logic [IW-1:0]             gnt_id;
  logic                      found;
  logic                      cap_en;
  int                        idx;

  // First valid requester at or after rr_ptr, wrapping upward.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_n       = state;
    cap_en        = 1'b0;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (found && rst_n) begin
          bus.req_ready = gnt;
          cap_en        = 1'b1;
          state_n       = CALC;
        end
      end
      CALC:    state_n = RESP;
      RESP:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  reduction_sched_reducer #(.DW(DATA_WIDTH), .GW(GW)) u_red (
    .grade (cap_grade),
    .poly  (cap_poly),
    .data  (cap_data),
    .res   (red_res),
    .err   (red_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cap_grade  <= '0;
      cap_poly   <= '0;
      cap_data   <= '0;
      cap_id     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (cap_en) begin
        cap_grade <= bus.req_grade[gnt_id];
        cap_poly  <= bus.req_poly[gnt_id];
        cap_data  <= bus.req_data[gnt_id];
        cap_id    <= gnt_id;
      end
      if (state == CALC) begin
        rsp_data_q <= red_res;
        rsp_err_q  <= red_err;
      end
      if (state == RESP && bus.rsp_ready)
        rr_ptr <= IW'((int'(cap_id) + 1) % NUM_REQ);
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = cap_id;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != IDLE);
endmodule
